// File: rtl/picomem_pkg.sv
// Shared types and helpers for the picorv32 native-bus memory responder.
package picomem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP,
    ST_GAP
  } state_t;

  localparam int ADDR_LSB = 2;

  // Unsigned offset compare: addresses below base wrap to a huge offset and fail.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned words);
    logic [31:0] offset;
    logic [31:0] limit;
    offset = addr - base;
    limit  = 32'(words) << ADDR_LSB;
    return offset < limit;
  endfunction

endpackage

// File: rtl/picomem_ram.sv
// Single-port word RAM with byte-enable writes and a registered read port.
module picomem_ram #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [MEM_WORDS];

  // NOTE: storage has no reset; a reset on a memory array prevents RAM inference.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/picomem_responder.sv
// Target side of the picorv32 native memory bus: wait states, stall, sticky fault capture.
module picomem_responder
  import picomem_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 0,
  parameter logic [31:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        err_clr,
  output logic        bus_err,
  output logic [31:0] bus_err_addr
);

  localparam int AW = $clog2(MEM_WORDS);

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [31:0]   addr_q;
  logic          write_q;
  logic          ok_q;
  logic          capture;
  logic          req_ok;
  logic          abort;
  logic          fault;
  logic [31:0]   fault_addr;
  logic [31:0]   offset;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          unused_bits;

  assign offset      = mem_addr - BASE_ADDR;
  assign ram_addr    = offset[ADDR_LSB +: AW];
  assign req_ok      = in_range(mem_addr, BASE_ADDR, MEM_WORDS);
  assign capture     = (state == ST_IDLE) && mem_valid;
  assign unused_bits = ^{mem_instr, offset[ADDR_LSB-1:0], offset[31:ADDR_LSB+AW]};

  // Writes commit and reads launch on the capture edge; out-of-range never touches the RAM.
  picomem_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
    .clk   (clk),
    .en    (capture && req_ok),
    .we    (mem_wstrb),
    .addr  (ram_addr),
    .wdata (mem_wdata),
    .rdata (ram_rdata)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          cnt_nxt   = 4'(LATENCY);
          state_nxt = (LATENCY > 0 || stall) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!mem_valid) begin
          abort     = 1'b1;
          cnt_nxt   = 4'd0;
          state_nxt = ST_IDLE;
        end else if (!stall) begin
          // Leave on the edge where the decremented count reaches zero; saturate there.
          if (cnt <= 4'd1) begin
            cnt_nxt   = 4'd0;
            state_nxt = ST_RESP;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      ST_RESP: begin
        if (!mem_valid) begin
          abort     = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign fault      = (capture && !req_ok) || abort;
  assign fault_addr = capture ? mem_addr : addr_q;

  assign mem_ready = (state == ST_RESP) && mem_valid;
  assign mem_rdata = (!mem_ready || write_q) ? 32'h0 :
                     ok_q                    ? ram_rdata : ERR_RDATA;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      addr_q       <= 32'h0;
      write_q      <= 1'b0;
      ok_q         <= 1'b0;
      bus_err      <= 1'b0;
      bus_err_addr <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) begin
        addr_q  <= mem_addr;
        write_q <= |mem_wstrb;
        ok_q    <= req_ok;
      end
      // A fault in the same cycle as a clear wins and records its own address.
      if (fault) begin
        bus_err <= 1'b1;
        if (!bus_err || err_clr) bus_err_addr <= fault_addr;
      end else if (err_clr) begin
        bus_err      <= 1'b0;
        bus_err_addr <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_picomem_responder.sv
// Scoreboard bench: three responders (LATENCY 0, 3, 4; the last with a nonzero base).
module tb_picomem_responder;

  localparam logic [31:0] B2  = 32'h0001_0000;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        valid   [3];
  logic        instr   [3];
  logic        stall   [3];
  logic        err_clr [3];
  logic        ready   [3];
  logic        bus_err [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [31:0] rdata   [3];
  logic [31:0] err_addr[3];
  logic [3:0]  wstrb   [3];

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    picomem_responder #(
      .MEM_WORDS (1024),
      .BASE_ADDR ((g == 2) ? B2 : 32'h0),
      .LATENCY   ((g == 0) ? 0 : ((g == 1) ? 3 : 4)),
      .ERR_RDATA (ERR)
    ) u_dut (
      .clk          (clk),
      .resetn       (resetn),
      .mem_valid    (valid[g]),
      .mem_instr    (instr[g]),
      .mem_ready    (ready[g]),
      .mem_addr     (addr[g]),
      .mem_wdata    (wdata[g]),
      .mem_wstrb    (wstrb[g]),
      .mem_rdata    (rdata[g]),
      .stall        (stall[g]),
      .err_clr      (err_clr[g]),
      .bus_err      (bus_err[g]),
      .bus_err_addr (err_addr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one request from a negedge in IDLE; expected read data goes on the scoreboard.
  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws, input logic [31:0] exp_rd,
                      input int exp_lat, input int stall_cyc, input string tag);
    int n;
    bit got;
    logic [31:0] exp_q;
    sb.push_back(exp_rd);
    valid[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (ready[d]) got = 1'b1;
      else stall[d] = (n <= stall_cyc);
    end
    stall[d] = 1'b0;
    exp_q = sb.pop_front();
    check({tag, "/ready"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "/lat"}, n, exp_lat);
      check({tag, "/rdata"}, rdata[d], exp_q);
      @(negedge clk);
      check({tag, "/gap_ready"}, 32'(ready[d]), 32'd0);
      check({tag, "/gap_rdata"}, rdata[d], 32'h0);
    end
    valid[d] = 1'b0; wstrb[d] = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    int seen;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; instr[i] = 1'b0; stall[i] = 1'b0; err_clr[i] = 1'b0;
      addr[i] = 32'h0; wdata[i] = 32'h0; wstrb[i] = 4'h0;
    end
    repeat (2) @(negedge clk);
    check("rst/ready", 32'(ready[0]), 32'd0);
    check("rst/rdata", rdata[0], 32'h0);
    check("rst/bus_err", 32'(bus_err[0]), 32'd0);
    check("rst/err_addr", err_addr[0], 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // LATENCY=0: full word, then byte enables.
    xact(0, 32'h10, 32'h1122_3344, 4'hF, 32'h0, 1, 0, "wr_full");
    xact(0, 32'h10, 32'h0, 4'h0, 32'h1122_3344, 1, 0, "rd_full");
    xact(0, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0, 1, 0, "wr_be");
    xact(0, 32'h10, 32'h0, 4'h0, 32'h11BB_33DD, 1, 0, "rd_be");
    check("no_err", 32'(bus_err[0]), 32'd0);

    // Out of range: first fault latches address; aliasing write must be dropped.
    xact(0, 32'h1000, 32'h0, 4'h0, ERR, 1, 0, "oor_rd");
    check("oor/bus_err", 32'(bus_err[0]), 32'd1);
    check("oor/err_addr", err_addr[0], 32'h1000);
    xact(0, 32'h1010, 32'h1234_5678, 4'hF, 32'h0, 1, 0, "oor_wr");
    check("oor2/err_addr", err_addr[0], 32'h1000);
    xact(0, 32'h10, 32'h0, 4'h0, 32'h11BB_33DD, 1, 0, "rd_after_oor");
    err_clr[0] = 1'b1;
    @(negedge clk);
    err_clr[0] = 1'b0;
    check("clr/bus_err", 32'(bus_err[0]), 32'd0);
    check("clr/err_addr", err_addr[0], 32'h0);

    // LATENCY=3 with two stall cycles from the first WAIT cycle.
    xact(1, 32'h20, 32'h5A5A_1234, 4'hF, 32'h0, 4, 0, "l3_wr");
    xact(1, 32'h20, 32'h0, 4'h0, 32'h5A5A_1234, 6, 2, "l3_stall_rd");

    // LATENCY=4, base 0x10000: write, then abort a read after two WAIT cycles.
    xact(2, B2 + 32'h8, 32'hCAFE_F00D, 4'hF, 32'h0, 5, 0, "l4_wr");
    valid[2] = 1'b1; addr[2] = B2 + 32'hC; wstrb[2] = 4'h0;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready[2]) seen++;
    end
    valid[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready[2]) seen++;
    end
    check("abort/no_ready", seen, 0);
    check("abort/bus_err", 32'(bus_err[2]), 32'd1);
    check("abort/err_addr", err_addr[2], B2 + 32'hC);
    xact(2, B2 + 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 5, 0, "after_abort");
    xact(2, 32'h0000_FFFC, 32'h0, 4'h0, ERR, 5, 0, "below_base");
    check("below_base/err_addr", err_addr[2], B2 + 32'hC);

    // Async reset while dut0 is in RESP and dut2 is mid-WAIT.
    valid[0] = 1'b1; addr[0] = 32'h10;
    valid[2] = 1'b1; addr[2] = B2 + 32'h8;
    @(negedge clk);
    check("pre_rst/ready0", 32'(ready[0]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("rst_async/ready0", 32'(ready[0]), 32'd0);
    check("rst_async/rdata0", rdata[0], 32'h0);
    check("rst_async/ready2", 32'(ready[2]), 32'd0);
    check("rst_async/bus_err2", 32'(bus_err[2]), 32'd0);
    check("rst_async/err_addr2", err_addr[2], 32'h0);
    valid[0] = 1'b0; valid[2] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    xact(2, B2 + 32'h8, 32'h0, 4'h0, 32'hCAFE_F00D, 5, 0, "post_rst2");
    xact(0, 32'h10, 32'h0, 4'h0, 32'h11BB_33DD, 1, 0, "post_rst0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
